vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, vertical equivalents in lines.
REQ-006 Parameters HS_POL and VS_POL, default 0 each, give the sync asserted level (0 means active-low).
REQ-007 Parameter CLK_DIV, default 2, range 1..16, gives clk cycles per pixel.
REQ-008 clk  input  1  single system clock, all logic on posedge.
REQ-009 rst  input  1  asynchronous, active-high reset.
REQ-010 run  input  1  request to generate frames.
REQ-011 irq_ack  input  1  clears frame_irq.
REQ-012 hsync, vsync  output  1 each  sync outputs.
REQ-013 video_on  output  1  high while both counters are in the active region.
REQ-014 x, y  output  10 each  current h_count and v_count.
REQ-015 pix_tick  output  1  one-clk strobe on which the counters advance.
REQ-016 line_start, frame_start  output  1 each  one-clk strobes.
REQ-017 busy  output  1  high in RUN or DRAIN.
REQ-018 frame_irq  output  1  sticky end-of-active-frame flag.

Function
REQ-019 Divider counts 0..CLK_DIV-1 and wraps; pix_tick is high on the clk where the divider equals CLK_DIV-1; with CLK_DIV=1, pix_tick stays high.
REQ-020 The divider runs only in RUN or DRAIN and holds at 0 in IDLE.
REQ-021 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on run=1; RUN->DRAIN on run=0; DRAIN->RUN on run=1; DRAIN->IDLE on the pix_tick where x=H_TOTAL-1 and y=V_TOTAL-1.
REQ-022 H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is the vertical equivalent; x has region order active, front porch, sync, back porch.
REQ-023 On pix_tick, x increments; at x=H_TOTAL-1 it wraps to 0 and y increments; at y=V_TOTAL-1 with x wrapping, y wraps to 0.
REQ-024 hsync=HS_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, otherwise ~HS_POL; vsync follows the same rule on y with V_* and VS_POL.
REQ-025 video_on=1 iff x<H_ACTIVE and y<V_ACTIVE.
REQ-026 hsync, vsync and video_on are registered and match the registered x and y on the same cycle, with zero added latency.
REQ-027 line_start pulses for one clk when x becomes 0; frame_start pulses when x and y both become 0, including the first pixel after IDLE->RUN.
REQ-028 In IDLE: x=y=0, syncs inactive, video_on=0, strobes 0.
REQ-029 Dropping run mid-frame does not truncate the frame; re-asserting run in DRAIN continues without a gap.

Reset
REQ-030 While rst=1: state=IDLE, divider=0, x=y=0, hsync=~HS_POL, vsync=~VS_POL, video_on=0, pix_tick=line_start=frame_start=0, busy=0, frame_irq=0.
REQ-031 Reset asserted mid-frame takes effect immediately, without waiting for a clk edge.
REQ-032 After rst falls, the first pixel follows run as from IDLE.

Configuration
REQ-033 With macro VGA_FRAME_IRQ_EN defined, frame_irq sets on the pix_tick where x wraps and y goes from V_ACTIVE-1 to V_ACTIVE.
REQ-034 With VGA_FRAME_IRQ_EN defined, frame_irq holds until a clk with irq_ack=1; if set and ack coincide, set wins.
REQ-035 Without VGA_FRAME_IRQ_EN, frame_irq is constant 0 and irq_ack is ignored, with no flag register synthesized.

Verification
REQ-036 Reset with defaults: rst=1 -> hsync=1, vsync=1, video_on=0, x=y=0, busy=0, frame_irq=0.
REQ-037 run=1 held, defaults -> frame_start 1 clk after run; hsync low for x=656..751 (192 clks); line 1600 clks; frame 840000 clks; video_on for x<640 and y<480.
REQ-038 run dropped at y=100 -> state DRAIN, frame completes to x=799 and y=524, then IDLE with busy=0; next frame_start only after run=1.
REQ-039 IRQ_EN defined -> frame_irq rises at x=0, y=480; irq_ack pulse -> 0; ack on the set cycle -> frame_irq stays 1.
REQ-040 rst pulsed at x=300, y=200 -> outputs reach reset values without a clk edge; rst released with run=1 -> new frame at x=0, y=0.
REQ-041 CLK_DIV=1, H/V tiny (4,1,1,1 / 2,1,1,1) -> pix_tick constant, line 7 clks, frame 35 clks, wraps exact.

Source files
------------

// File: rtl/vga_timing_ctrl_if.sv
// Signal bundle between the VGA timing controller and its consumer.
// The master side (the controller) receives run/irq_ack and drives the
// timing, position, strobe and status outputs.
interface vga_timing_ctrl_if;
    logic       run;
    logic       irq_ack;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       pix_tick;
    logic       line_start;
    logic       frame_start;
    logic       busy;
    logic       frame_irq;

    modport master (
        input  run, irq_ack,
        output hsync, vsync, video_on, x, y, pix_tick,
               line_start, frame_start, busy, frame_irq
    );

    modport slave (
        output run, irq_ack,
        input  hsync, vsync, video_on, x, y, pix_tick,
               line_start, frame_start, busy, frame_irq
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: pixel-rate divider, horizontal/vertical counters,
// registered sync/video_on aligned with x/y, and an IDLE/RUN/DRAIN FSM that
// always completes the frame in flight before stopping.
// Optional feature macro: VGA_FRAME_IRQ_EN adds the sticky frame_irq flag
// (set at the end of the active area, cleared by irq_ack).
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2
) (
    input  logic               clk,
    input  logic               rst,
    vga_timing_ctrl_if.master  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG     = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG     = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]  DIV_MAX    = 4'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t     state_reg, state_next;
    logic [3:0] div_reg, div_next;
    logic [9:0] x_reg, x_next;
    logic [9:0] y_reg, y_next;
    logic       hsync_reg, hsync_next;
    logic       vsync_reg, vsync_next;
    logic       video_reg, video_next;
    logic       line_reg, line_next;
    logic       frame_reg, frame_next;

    logic active;
    logic tick;
    logic x_wrap;
    logic frame_end;

    assign active    = (state_reg != IDLE);
    assign tick      = active && (div_reg == DIV_MAX);
    assign x_wrap    = tick && (x_reg == H_LAST);
    assign frame_end = x_wrap && (y_reg == V_LAST);

    // Next state: stopping only happens on the last pixel of a frame
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.run) state_next = RUN;
            RUN:     if (!bus.run) state_next = DRAIN;
            DRAIN: begin
                if (bus.run)        state_next = RUN;
                else if (frame_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Next divider/counter/strobe/sync values; syncs are decoded from the
    // next position so the registered outputs line up with x/y
    always_comb begin
        div_next   = div_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        line_next  = 1'b0;
        frame_next = 1'b0;
        if (state_next == IDLE) begin
            div_next = 4'd0;
            x_next   = 10'd0;
            y_next   = 10'd0;
        end else if (state_reg == IDLE) begin
            // First pixel of a fresh frame is shown immediately at (0,0)
            div_next   = 4'd0;
            x_next     = 10'd0;
            y_next     = 10'd0;
            line_next  = 1'b1;
            frame_next = 1'b1;
        end else begin
            div_next = tick ? 4'd0 : div_reg + 4'd1;
            if (x_wrap) begin
                x_next     = 10'd0;
                line_next  = 1'b1;
                frame_next = (y_reg == V_LAST);
                y_next     = (y_reg == V_LAST) ? 10'd0 : y_reg + 10'd1;
            end else if (tick) begin
                x_next = x_reg + 10'd1;
            end
        end

        hsync_next = ~HS_POL;
        vsync_next = ~VS_POL;
        video_next = 1'b0;
        if (state_next != IDLE) begin
            if ({1'b0, x_next} >= HS_BEG && {1'b0, x_next} < HS_END)
                hsync_next = HS_POL;
            if ({1'b0, y_next} >= VS_BEG && {1'b0, y_next} < VS_END)
                vsync_next = VS_POL;
            video_next = ({1'b0, x_next} < H_ACT) && ({1'b0, y_next} < V_ACT);
        end
    end

    // State, counters and all timing outputs, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            div_reg   <= 4'd0;
            x_reg     <= 10'd0;
            y_reg     <= 10'd0;
            hsync_reg <= ~HS_POL;
            vsync_reg <= ~VS_POL;
            video_reg <= 1'b0;
            line_reg  <= 1'b0;
            frame_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            hsync_reg <= hsync_next;
            vsync_reg <= vsync_next;
            video_reg <= video_next;
            line_reg  <= line_next;
            frame_reg <= frame_next;
        end
    end

`ifdef VGA_FRAME_IRQ_EN
    logic irq_reg;
    logic irq_set;

    // Leaving the last active line marks the end of the visible frame
    assign irq_set = x_wrap && (y_reg == V_ACT_LAST);

    // Sticky flag; a set on the same clk as an ack takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              irq_reg <= 1'b0;
        else if (irq_set)     irq_reg <= 1'b1;
        else if (bus.irq_ack) irq_reg <= 1'b0;
    end

    assign bus.frame_irq = irq_reg;
`else
    logic unused_irq;
    assign unused_irq    = bus.irq_ack ^ (|V_ACT_LAST);
    assign bus.frame_irq = 1'b0;
`endif

    assign bus.pix_tick    = tick;
    assign bus.busy        = active;
    assign bus.x           = x_reg;
    assign bus.y           = y_reg;
    assign bus.hsync       = hsync_reg;
    assign bus.vsync       = vsync_reg;
    assign bus.video_on    = video_reg;
    assign bus.line_start  = line_reg;
    assign bus.frame_start = frame_reg;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: a default-parameter instance for line
// timing and asynchronous reset, and a tiny CLK_DIV=1 instance (7x5 frame,
// active-high syncs) for full-frame wraps, drain/resume and frame_irq.
module tb_vga_timing_ctrl;
    logic clk = 1'b0;
    logic rst_d;
    logic rst_t;
    int   checks   = 0;
    int   failures = 0;

`ifdef VGA_FRAME_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    vga_timing_ctrl_if bus_d ();
    vga_timing_ctrl_if bus_t ();

    vga_timing_ctrl u_dut_def (
        .clk (clk),
        .rst (rst_d),
        .bus (bus_d)
    );

    vga_timing_ctrl #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b1), .VS_POL (1'b1), .CLK_DIV (1)
    ) u_dut_tiny (
        .clk (clk),
        .rst (rst_t),
        .bus (bus_t)
    );

    // Observation vector: {x, y, hsync, vsync, video_on, pix_tick, line_start, frame_start, busy}
    function automatic logic [26:0] obs_d();
        return {bus_d.x, bus_d.y, bus_d.hsync, bus_d.vsync, bus_d.video_on,
                bus_d.pix_tick, bus_d.line_start, bus_d.frame_start, bus_d.busy};
    endfunction

    function automatic logic [26:0] obs_t();
        return {bus_t.x, bus_t.y, bus_t.hsync, bus_t.vsync, bus_t.video_on,
                bus_t.pix_tick, bus_t.line_start, bus_t.frame_start, bus_t.busy};
    endfunction

    // Expected tiny-frame vector at position p (clocks since frame_start, run continuous)
    function automatic logic [26:0] exp_tiny(input int p);
        int px;
        int py;
        px = p % 7;
        py = (p / 7) % 5;
        return {10'(px), 10'(py), (px == 5), (py == 3), (px < 4 && py < 2),
                1'b1, (px == 0), (p % 35 == 0), 1'b1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_d = 1'b1;
        rst_t = 1'b1;
        bus_d.run = 1'b0; bus_d.irq_ack = 1'b0;
        bus_t.run = 1'b0; bus_t.irq_ack = 1'b0;
        step();
        step();
        checks++;
        if (obs_d() !== {10'd0, 10'd0, 1'b1, 1'b1, 5'b0}) begin
            failures++;
            $display("FAIL reset_default: got %h expected %h", obs_d(), {10'd0, 10'd0, 1'b1, 1'b1, 5'b0});
        end
        checks++;
        if (bus_d.frame_irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq: got %b expected 0", bus_d.frame_irq);
        end
        checks++;
        if (obs_t() !== 27'd0) begin
            failures++;
            $display("FAIL reset_tiny_pol: got %h expected %h", obs_t(), 27'd0);
        end
        rst_d = 1'b0;
        rst_t = 1'b0;
        step();
        checks++;
        if (obs_d() !== {10'd0, 10'd0, 1'b1, 1'b1, 5'b0}) begin
            failures++;
            $display("FAIL idle_after_reset: got %h expected %h", obs_d(), {10'd0, 10'd0, 1'b1, 1'b1, 5'b0});
        end
        $display("reset: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_default_line();
        int hs_low;
        int ex;
        int ey;
        logic [26:0] e;
        bus_d.run = 1'b1;
        step();
        checks++;
        if (obs_d() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL first_pixel: got %h expected %h", obs_d(),
                     {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
        end
        hs_low = 0;
        for (int k = 1; k <= 1600; k++) begin
            step();
            ex = (k / 2) % 800;
            ey = k / 1600;
            e = {10'(ex), 10'(ey), !(ex >= 656 && ex < 752), 1'b1, (ex < 640 && ey < 480),
                 (k % 2 == 1), (k == 1600), 1'b0, 1'b1};
            if (bus_d.hsync === 1'b0) hs_low++;
            checks++;
            if (obs_d() !== e) begin
                failures++;
                $display("FAIL line_clk%0d: got %h expected %h", k, obs_d(), e);
            end
        end
        checks++;
        if (hs_low != 192) begin
            failures++;
            $display("FAIL hsync_width: got %0d clks expected 192", hs_low);
        end
        repeat (600) step();
        checks++;
        if (bus_d.x !== 10'd300 || bus_d.y !== 10'd1) begin
            failures++;
            $display("FAIL pos_2200: got x=%0d y=%0d expected x=300 y=1", bus_d.x, bus_d.y);
        end
        $display("default_line: hsync_low=%0d checks=%0d failures=%0d", hs_low, checks, failures);
    endtask

    task automatic test_async_reset();
        #2;
        rst_d = 1'b1;
        #1;
        checks++;
        if (obs_d() !== {10'd0, 10'd0, 1'b1, 1'b1, 5'b0}) begin
            failures++;
            $display("FAIL async_reset: got %h expected %h", obs_d(), {10'd0, 10'd0, 1'b1, 1'b1, 5'b0});
        end
        step();
        rst_d = 1'b0;
        step();
        checks++;
        if (bus_d.frame_start !== 1'b1 || bus_d.x !== 10'd0 || bus_d.y !== 10'd0 || bus_d.busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_after_reset: got fs=%b x=%0d y=%0d busy=%b expected fs=1 x=0 y=0 busy=1",
                     bus_d.frame_start, bus_d.x, bus_d.y, bus_d.busy);
        end
        step();
        step();
        checks++;
        if (bus_d.x !== 10'd1) begin
            failures++;
            $display("FAIL restart_advance: got x=%0d expected 1", bus_d.x);
        end
        bus_d.run = 1'b0;
        $display("async_reset: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_tiny_frames();
        bus_t.run = 1'b1;
        for (int p = 0; p <= 70; p++) begin
            step();
            checks++;
            if (obs_t() !== exp_tiny(p)) begin
                failures++;
                $display("FAIL tiny_frame_p%0d: got %h expected %h", p, obs_t(), exp_tiny(p));
            end
        end
        $display("tiny_frames: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_drain();
        // Continues from the frame_start at the end of test_tiny_frames
        for (int p = 1; p <= 34; p++) begin
            if (p == 17) bus_t.run = 1'b0;
            step();
            checks++;
            if (obs_t() !== exp_tiny(p)) begin
                failures++;
                $display("FAIL drain_p%0d: got %h expected %h", p, obs_t(), exp_tiny(p));
            end
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs_t() !== 27'd0) begin
                failures++;
                $display("FAIL drain_idle%0d: got %h expected %h", i, obs_t(), 27'd0);
            end
        end
        bus_t.run = 1'b1;
        step();
        checks++;
        if (obs_t() !== exp_tiny(0)) begin
            failures++;
            $display("FAIL drain_restart: got %h expected %h", obs_t(), exp_tiny(0));
        end
        $display("drain: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_back_to_back();
        // run dropped for three clocks mid-frame: no gap, no truncation
        for (int p = 1; p <= 40; p++) begin
            if (p == 6) bus_t.run = 1'b0;
            if (p == 9) bus_t.run = 1'b1;
            step();
            checks++;
            if (obs_t() !== exp_tiny(p)) begin
                failures++;
                $display("FAIL resume_p%0d: got %h expected %h", p, obs_t(), exp_tiny(p));
            end
        end
        $display("back_to_back: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_irq();
        logic e;
        #2;
        rst_t = 1'b1;
        #1;
        checks++;
        if (bus_t.frame_irq !== 1'b0 || bus_t.busy !== 1'b0) begin
            failures++;
            $display("FAIL tiny_async_reset: got irq=%b busy=%b expected 0 0", bus_t.frame_irq, bus_t.busy);
        end
        step();
        rst_t = 1'b0;
        step();
        checks++;
        if (bus_t.frame_start !== 1'b1) begin
            failures++;
            $display("FAIL irq_frame_start: got %b expected 1", bus_t.frame_start);
        end
        for (int p = 1; p <= 55; p++) begin
            bus_t.irq_ack = (p == 19 || p == 49);
            step();
            bus_t.irq_ack = 1'b0;
            e = IRQ_EN && ((p >= 14 && p < 19) || p >= 49);
            checks++;
            if (bus_t.frame_irq !== e) begin
                failures++;
                $display("FAIL irq_p%0d: got %b expected %b", p, bus_t.frame_irq, e);
            end
        end
        $display("irq: enabled=%0d checks=%0d failures=%0d", IRQ_EN, checks, failures);
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_async_reset();
        test_tiny_frames();
        test_drain();
        test_back_to_back();
        test_irq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
